// File: rtl/ysyx_22040895_alu_seq_pkg.sv
// Shared opcode and FSM encodings for the ysyx_22040895 sequential execute unit.
package ysyx_22040895_alu_seq_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  typedef enum logic [4:0] {
    ALU_OP_ADD    = 5'h00,
    ALU_OP_SUB    = 5'h01,
    ALU_OP_SLT    = 5'h02,
    ALU_OP_SLL    = 5'h03,
    ALU_OP_SRL    = 5'h04,
    ALU_OP_SRA    = 5'h05,
    ALU_OP_AND    = 5'h06,
    ALU_OP_OR     = 5'h07,
    ALU_OP_XOR    = 5'h08,
    ALU_OP_SLTU   = 5'h09,
    ALU_OP_MUL    = 5'h10,
    ALU_OP_MULH   = 5'h11,
    ALU_OP_MULHSU = 5'h12,
    ALU_OP_MULHU  = 5'h13,
    ALU_OP_DIV    = 5'h14,
    ALU_OP_DIVU   = 5'h15,
    ALU_OP_REM    = 5'h16,
    ALU_OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mop(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/ysyx_22040895_alu_seq_if.sv
// Request/response bundle between the EX stage and the sequential ALU.
interface ysyx_22040895_alu_seq_if
  import ysyx_22040895_alu_seq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [4:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            lt_o;
  logic            ltu_o;
  logic            zero_o;

  modport master (
    output flush_i, in_valid_i, op_i, word_i, op1_i, op2_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, lt_o, ltu_o, zero_o
  );

  modport slave (
    input  flush_i, in_valid_i, op_i, word_i, op1_i, op2_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, lt_o, ltu_o, zero_o
  );
endinterface

// File: rtl/ysyx_22040895_muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider on shared registers.
module ysyx_22040895_muldiv_iter
  import ysyx_22040895_alu_seq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  alu_op_e         op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned CW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   acc_q, acc_d;   // mul: product high half; div: partial remainder
  logic [XLEN-1:0] sh_q, sh_d;     // mul: multiplier bits; div: dividend in, quotient out
  logic [XLEN-1:0] opb_q, opb_d;
  logic            is_div_q, is_div_d, hi_q, hi_d, neg_q, neg_d, word_q, word_d;

  logic            a_sgn, b_sgn, a_neg, b_neg, s_div, s_hi;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [XLEN:0]   it_acc, sum, trial;
  logic [XLEN-1:0] it_sh, div_val, res;
  logic [2*XLEN-1:0] prod;
  logic            ge;
  logic [CW-1:0]   last;

  always_comb begin
    a_sgn = (op_i == ALU_OP_MULH) | (op_i == ALU_OP_MULHSU) |
            (op_i == ALU_OP_DIV)  | (op_i == ALU_OP_REM);
    b_sgn = (op_i == ALU_OP_MULH) | (op_i == ALU_OP_DIV) | (op_i == ALU_OP_REM);
    a_ext = word_i ? (a_sgn ? sext32(a_i[31:0]) : XLEN'(a_i[31:0])) : a_i;
    b_ext = word_i ? (b_sgn ? sext32(b_i[31:0]) : XLEN'(b_i[31:0])) : b_i;
    a_neg = a_sgn & a_ext[XLEN-1];
    b_neg = b_sgn & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    s_div = op_i[2];
    s_hi  = s_div ? op_i[1] : (op_i[1:0] != 2'b00);
  end

  always_comb begin
    sum   = acc_q + (sh_q[0] ? {1'b0, opb_q} : '0);
    trial = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
    ge    = trial >= {1'b0, opb_q};
    if (is_div_q) begin
      it_acc = ge ? trial - {1'b0, opb_q} : trial;
      it_sh  = {sh_q[XLEN-2:0], ge};
    end else begin
      it_acc = {1'b0, sum[XLEN:1]};
      it_sh  = {sum[0], sh_q[XLEN-1:1]};
    end
  end

  // Result is formed from this cycle's iteration output so the parent can capture it on the final edge.
  always_comb begin
    prod = {it_acc[XLEN-1:0], it_sh};
    if (word_q) prod = prod >> 32;
    if (neg_q)  prod = -prod;
    if (hi_q)   prod = word_q ? prod >> 32 : prod >> XLEN;
    div_val = hi_q ? it_acc[XLEN-1:0] : it_sh;
    if (neg_q) div_val = -div_val;
    res      = is_div_q ? div_val : prod[XLEN-1:0];
    result_o = word_q ? sext32(res[31:0]) : res;
  end

  always_comb begin
    last     = word_q ? CW'(31) : CW'(XLEN-1);
    done_o   = busy_q & (cnt_q == last);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    neg_d    = neg_q;
    word_d   = word_q;
    if (flush_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      acc_d    = '0;
      sh_d     = s_div ? (word_i ? a_mag << 32 : a_mag) : b_mag;
      opb_d    = s_div ? b_mag : a_mag;
      is_div_d = s_div;
      hi_d     = s_hi;
      neg_d    = (s_div & s_hi) ? a_neg : (a_neg ^ b_neg);
      word_d   = word_i;
    end else if (busy_q) begin
      acc_d  = it_acc;
      sh_d   = it_sh;
      cnt_d  = done_o ? '0 : cnt_q + 1'b1;
      busy_d = ~done_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= 1'b0;
      neg_q    <= 1'b0;
      word_q   <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      neg_q    <= neg_d;
      word_q   <= word_d;
    end
  end

endmodule

// File: rtl/ysyx_22040895_alu_seq.sv
// Registered, handshaked EX-stage ALU: single-cycle base ops, iterative RV64M ops.
module ysyx_22040895_alu_seq
  import ysyx_22040895_alu_seq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22040895_alu_seq_if.slave bus
);
  localparam bit              HAS_W = (XLEN == 64);
  localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            lt_q, lt_d, ltu_q, ltu_d, zero_q, zero_d;

  alu_op_e         op;
  logic            wmode, accept, md_start, md_done;
  logic [XLEN-1:0] op1c, op2c, srl_src, sra_src, base_r, quick_res, dvd_e, fast_res, md_result;
  logic [SHW-1:0]  sh_amt;
  logic            cmp_lt, cmp_ltu, is_div, dz, ovf, fast, rem_sel;

  assign op    = alu_op_e'(bus.op_i);
  assign wmode = HAS_W & bus.word_i;

  assign bus.in_ready_o  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready_i);
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.result_o    = result_q;
  assign bus.lt_o        = lt_q;
  assign bus.ltu_o       = ltu_q;
  assign bus.zero_o      = zero_q;

  always_comb begin
    op1c    = wmode ? sext32(bus.op1_i[31:0]) : bus.op1_i;
    op2c    = wmode ? sext32(bus.op2_i[31:0]) : bus.op2_i;
    cmp_lt  = $signed(op1c) < $signed(op2c);
    cmp_ltu = op1c < op2c;
    sh_amt  = wmode ? SHW'(bus.op2_i[4:0]) : bus.op2_i[SHW-1:0];
    srl_src = wmode ? XLEN'(bus.op1_i[31:0]) : bus.op1_i;
    sra_src = op1c;
    case (op)
      ALU_OP_ADD:  base_r = bus.op1_i + bus.op2_i;
      ALU_OP_SUB:  base_r = bus.op1_i - bus.op2_i;
      ALU_OP_SLT:  base_r = XLEN'(cmp_lt);
      ALU_OP_SLL:  base_r = bus.op1_i << sh_amt;
      ALU_OP_SRL:  base_r = srl_src >> sh_amt;
      ALU_OP_SRA:  base_r = $signed(sra_src) >>> sh_amt;
      ALU_OP_AND:  base_r = bus.op1_i & bus.op2_i;
      ALU_OP_OR:   base_r = bus.op1_i | bus.op2_i;
      ALU_OP_XOR:  base_r = bus.op1_i ^ bus.op2_i;
      ALU_OP_SLTU: base_r = XLEN'(cmp_ltu);
      default:     base_r = '0;
    endcase
  end

  // Divide-by-zero and signed overflow bypass the iterator and finish in one cycle.
  always_comb begin
    is_div   = is_mop(bus.op_i) & bus.op_i[2];
    rem_sel  = (op == ALU_OP_REM) | (op == ALU_OP_REMU);
    dvd_e    = op1c;
    dz       = wmode ? (bus.op2_i[31:0] == '0) : (bus.op2_i == '0);
    ovf      = ((op == ALU_OP_DIV) | (op == ALU_OP_REM)) &
               (wmode ? (bus.op1_i[31:0] == 32'h8000_0000) & (bus.op2_i[31:0] == '1)
                      : (bus.op1_i == XMIN) & (bus.op2_i == '1));
    fast     = is_div & (dz | ovf);
    fast_res = dz ? (rem_sel ? dvd_e : '1) : (rem_sel ? '0 : dvd_e);
    if (fast)                  quick_res = fast_res;
    else if (is_mop(bus.op_i)) quick_res = '0;
    else                       quick_res = wmode ? sext32(base_r[31:0]) : base_r;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    zero_d   = zero_q;
    md_start = 1'b0;
    accept   = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
    if (bus.flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_BUSY: if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_result;
          zero_d   = (md_result == '0);
        end
        ST_DONE: if (bus.out_ready_i) state_d = ST_IDLE;
        default: ;
      endcase
      if (accept) begin
        lt_d  = cmp_lt;
        ltu_d = cmp_ltu;
        if (is_mop(bus.op_i) & ~fast) begin
          state_d  = ST_BUSY;
          md_start = 1'b1;
        end else begin
          state_d  = ST_DONE;
          result_d = quick_res;
          zero_d   = (quick_res == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
      zero_q   <= zero_d;
    end
  end

  ysyx_22040895_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (bus.flush_i),
    .start_i  (md_start),
    .op_i     (op),
    .word_i   (wmode),
    .a_i      (bus.op1_i),
    .b_i      (bus.op2_i),
    .done_o   (md_done),
    .result_o (md_result)
  );

endmodule

// File: tb/tb_ysyx_22040895_alu_seq.sv
// Directed vector bench for ysyx_22040895_alu_seq at XLEN=64.
module tb_ysyx_22040895_alu_seq;
  import ysyx_22040895_alu_seq_pkg::*;

  localparam int unsigned XLEN = 64;

  typedef struct {
    logic [4:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        lt;
    logic        ltu;
    logic        zero;
    int unsigned lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  ysyx_22040895_alu_seq_if #(.XLEN(XLEN)) bus ();
  ysyx_22040895_alu_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [4:0] op, input logic w, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] r, input logic lt,
                              input logic ltu, input logic z, input int unsigned lat);
    vec_t v;
    v.op = op; v.word = w; v.a = a; v.b = b; v.res = r;
    v.lt = lt; v.ltu = ltu; v.zero = z; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [4:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.op_i = op; bus.word_i = w; bus.op1_i = a; bus.op2_i = b; bus.in_valid_i = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned cyc;
    logic ready_in_busy;
    drive(v.op, v.word, v.a, v.b);
    cyc = 0;
    while (!bus.in_ready_o && cyc < 100) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    cyc = 1;
    ready_in_busy = 1'b0;
    while (!bus.out_valid_o && cyc < 200) begin
      if (bus.in_ready_o) ready_in_busy = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(v.lat));
    check({tag, " result"}, bus.result_o, v.res);
    check({tag, " lt"}, 64'(bus.lt_o), 64'(v.lt));
    check({tag, " ltu"}, 64'(bus.ltu_o), 64'(v.ltu));
    check({tag, " zero"}, 64'(bus.zero_o), 64'(v.zero));
    if (v.lat > 1) check({tag, " in_ready in busy"}, 64'(ready_in_busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned cyc;
    logic seen;
    logic [63:0] held;

    rst = 1'b1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.op_i = '0; bus.word_i = 1'b0;
    bus.op1_i = '0; bus.op2_i = '0; bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset in_ready", 64'(bus.in_ready_o), 64'd1);
    check("reset out_valid", 64'(bus.out_valid_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    check("reset flags", {61'd0, bus.lt_o, bus.ltu_o, bus.zero_o}, 64'd0);
    @(posedge clk); #1;

    //  op             w     a                      b                      result                 lt ltu z  lat
    add(ALU_OP_ADD,    1'b0, 64'd5,                 -64'sd7,               64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 1);
    add(ALU_OP_SUB,    1'b0, 64'd10,                64'd10,                64'd0,                 0, 0, 1, 1);
    add(ALU_OP_SLL,    1'b1, 64'h1,                 64'h25,                64'h20,                1, 1, 0, 1);
    add(ALU_OP_SRA,    1'b0, 64'h8000_0000_0000_0000, 64'd63,              64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 1);
    add(ALU_OP_SRL,    1'b0, 64'h8000_0000_0000_0000, 64'h7F,              64'd1,                 1, 0, 0, 1);
    add(ALU_OP_SRA,    1'b1, 64'h0000_0000_8000_0000, 64'd4,               64'hFFFF_FFFF_F800_0000, 1, 0, 0, 1);
    add(ALU_OP_SRL,    1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4,               64'h0800_0000,         1, 0, 0, 1);
    add(ALU_OP_SLT,    1'b0, -64'sd1,               64'd1,                 64'd1,                 1, 0, 0, 1);
    add(ALU_OP_SLTU,   1'b0, -64'sd1,               64'd1,                 64'd0,                 1, 0, 1, 1);
    add(ALU_OP_AND,    1'b0, 64'hF0F0,              64'hFF00,              64'hF000,              1, 1, 0, 1);
    add(ALU_OP_OR,     1'b0, 64'hF0F0,              64'h0F0F,              64'hFFFF,              0, 0, 0, 1);
    add(ALU_OP_XOR,    1'b0, 64'hFF,                64'hFF,                64'd0,                 0, 0, 1, 1);
    add(ALU_OP_ADD,    1'b1, 64'h7FFF_FFFF,         64'd1,                 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 1);
    add(5'h0A,         1'b0, 64'd3,                 64'd4,                 64'd0,                 1, 1, 1, 1);
    add(ALU_OP_DIV,    1'b0, 64'h8000_0000_0000_0000, -64'sd1,             64'h8000_0000_0000_0000, 1, 1, 0, 1);
    add(ALU_OP_REM,    1'b0, 64'h8000_0000_0000_0000, -64'sd1,             64'd0,                 1, 1, 1, 1);
    add(ALU_OP_DIVU,   1'b0, 64'd7,                 64'd0,                 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
    add(ALU_OP_REMU,   1'b0, 64'd7,                 64'd0,                 64'd7,                 0, 0, 0, 1);
    add(ALU_OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,               64'd1,                 1, 0, 0, 65);
    add(ALU_OP_MUL,    1'b0, 64'd6,                 -64'sd7,               64'hFFFF_FFFF_FFFF_FFD6, 0, 1, 0, 65);
    add(ALU_OP_MULH,   1'b0, -64'sd1,               -64'sd1,               64'd0,                 0, 0, 1, 65);
    add(ALU_OP_MULH,   1'b0, 64'h4000_0000_0000_0000, 64'd4,               64'd1,                 0, 0, 0, 65);
    add(ALU_OP_MULHSU, 1'b0, -64'sd1,               64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 65);
    add(ALU_OP_DIV,    1'b1, -64'sd7,               64'd2,                 64'hFFFF_FFFF_FFFF_FFFD, 1, 0, 0, 33);
    add(ALU_OP_REM,    1'b0, -64'sd7,               64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 65);
    add(ALU_OP_DIVU,   1'b0, 64'd100,               64'd7,                 64'd14,                0, 0, 0, 65);
    add(ALU_OP_REMU,   1'b0, 64'd100,               64'd7,                 64'd2,                 0, 0, 0, 65);
    add(ALU_OP_MUL,    1'b1, 64'h8000_0000,         64'd2,                 64'd0,                 1, 0, 1, 33);
    add(ALU_OP_DIV,    1'b0, -64'sd20,              64'd3,                 64'hFFFF_FFFF_FFFF_FFFA, 1, 0, 0, 65);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // DIVW under back-pressure, a queued ADD must wait and then go back-to-back
    bus.out_ready_i = 1'b0;
    drive(ALU_OP_DIV, 1'b1, -64'sd7, 64'd2);
    @(posedge clk); #1;
    drive(ALU_OP_ADD, 1'b0, 64'h100, 64'h23);
    cyc = 1;
    seen = 1'b0;
    while (!bus.out_valid_o && cyc < 200) begin
      if (bus.in_ready_o) seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("stall latency", 64'(cyc), 64'd33);
    check("stall ready in busy", 64'(seen), 64'd0);
    held = 64'hFFFF_FFFF_FFFF_FFFD;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d result", k), bus.result_o, held);
      check($sformatf("stall%0d valid", k), 64'(bus.out_valid_o), 64'd1);
      check($sformatf("stall%0d in_ready", k), 64'(bus.in_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    check("stall end result", bus.result_o, held);
    bus.out_ready_i = 1'b1;
    #1;
    check("b2b in_ready", 64'(bus.in_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check("b2b valid", 64'(bus.out_valid_o), 64'd1);
    check("b2b result", bus.result_o, 64'h123);
    @(posedge clk); #1;
    check("b2b drained", 64'(bus.out_valid_o), 64'd0);

    // flush at iteration 10 of a MUL
    drive(ALU_OP_MUL, 1'b0, 64'd3, 64'd5);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush in_ready", 64'(bus.in_ready_o), 64'd1);
    seen = bus.out_valid_o;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) seen = 1'b1;
    end
    check("flush no out_valid", 64'(seen), 64'd0);
    begin
      vec_t v;
      v.op = ALU_OP_MUL; v.word = 1'b0; v.a = 64'd3; v.b = 64'd5; v.res = 64'd15;
      v.lt = 1'b1; v.ltu = 1'b1; v.zero = 1'b0; v.lat = 65;
      run_vec(v, "post-flush mul");
    end

    // asynchronous reset in the middle of a DIVU
    drive(ALU_OP_DIVU, 1'b0, 64'd100, 64'd7);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst in_ready", 64'(bus.in_ready_o), 64'd1);
    check("arst out_valid", 64'(bus.out_valid_o), 64'd0);
    check("arst result", bus.result_o, 64'd0);
    check("arst flags", {61'd0, bus.lt_o, bus.ltu_o, bus.zero_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      vec_t v;
      v.op = ALU_OP_DIVU; v.word = 1'b0; v.a = 64'd100; v.b = 64'd7; v.res = 64'd14;
      v.lt = 1'b0; v.ltu = 1'b0; v.zero = 1'b0; v.lat = 65;
      run_vec(v, "post-reset divu");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_alu_seq.md
# ysyx_22040895_alu_seq

Registered, handshaked execute unit for the ysyx_22040895 EX stage, parametrised in XLEN. It replaces the purely combinational integer ALU and adds:
- RV64M multiply/divide on a shared iterative datapath;
- RV64 word (32-bit, `*W`) mode;
- correctly masked shift amounts;
- valid/ready flow control so the pipeline stalls on multi-cycle ops.

## Interface
Parameters:
- XLEN, 64, datapath width; must be 32 or 64.
- SHW, $clog2(XLEN), shift-amount width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush_i  in  1  synchronous abort of any in-flight or held op.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- op_i  in  5  opcode; values below.
- word_i  in  1  word mode: operate on bits [31:0], sign-extend the 32-bit result to XLEN. Ignored when XLEN=32.
- op1_i, op2_i  in  XLEN  operands.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result.
- lt_o, ltu_o, zero_o  out  1  signed less-than, unsigned less-than, result==0 (latched with result).

## Operation
- Opcodes, base ops (same numbering as the existing aluop):
  - 0x00 ADD, 0x01 SUB, 0x02 SLT, 0x03 SLL, 0x04 SRL, 0x05 SRA, 0x06 AND, 0x07 OR, 0x08 XOR, 0x09 SLTU.
- Opcodes, M ops:
  - 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU.
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
- Any other opcode: result 0, completes on the base-op path.
- Shifts:
  - Amount is op2[SHW-1:0], or op2[4:0] in word mode.
  - SRA/SRAW shift in the sign of the effective operand.
- lt/ltu compare full op1/op2 for every opcode (branch use); in word mode they compare sign-extended low halves.
- Multiply: radix-2 shift-add over N = XLEN (32 in word mode) iterations.
  - Signed variants negate inputs up front and correct the sign at the end.
  - MUL returns the low N bits; MULH* return the high N bits.
- Divide: restoring, N iterations, magnitude-based with a sign fixup.
  - Divisor==0: quotient = all-ones, remainder = dividend, 1 cycle.
  - Signed overflow (min / −1): quotient = dividend, remainder = 0, 1 cycle.
- FSM:
  - IDLE → BUSY on an accepted M op that is not a fast case.
  - IDLE → DONE on an accepted base op or fast case.
  - BUSY → DONE when the iteration counter reaches N−1.
  - DONE → IDLE on out_ready_i.
  - DONE → BUSY/DONE directly if a new request is accepted in the same cycle as out_ready_i (back-to-back).
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i).
- flush_i: next state IDLE, out_valid_o=0, and the counter is cleared. It has priority over a simultaneous accept.

## Timing
- Reset state:
  - IDLE, in_ready_o=1, out_valid_o=0.
  - result_o=0, flags 0, counter 0.
- Base op / fast case: accepted at edge k, out_valid_o high after edge k+1 (latency 1).
- M op: out_valid_o after edge k+1+N. That is 65 cycles at XLEN=64, 33 in word mode.
- result_o and flags hold stable while out_valid_o=1 and out_ready_i=0.
- Reset asserted mid-iteration: returns to reset state immediately, with no partial result visible.

## Structure
- Shared package/define file holds:
  - the opcode constants (ALU_OP_* 5-bit) and FSM state encoding;
  - the XLEN default, extending the existing define header.
- One sub-module, ysyx_22040895_muldiv_iter. It holds the shared accumulator/shift registers, counter and sign fixup, with start/done handshaking to the parent.
- Base-op logic stays combinational in the parent, feeding the output register.

## Test plan
- ADD 5 + (−7), XLEN=64 → result 0xFFFF_FFFF_FFFF_FFFE, lt=0, out_valid 1 cycle after accept.
- SLLW op1=0x1, op2=0x25, word=1 → amount 5, result 0x20. SRA op1=0x8000_0000_0000_0000, op2=63 → all-ones.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → result 1 after 65 cycles, in_ready_o=0 throughout BUSY.
- DIV 0x8000_0000_0000_0000 / −1 → same value; REM → 0. DIVU 7/0 → all-ones; REMU 7/0 → 7. All four complete in 1 cycle.
- DIVW op1=−7, op2=2 → 0xFFFF_FFFF_FFFF_FFFD after 33 cycles, with out_ready_i held low 3 cycles → result stable, no new accept.
- flush_i at iteration 10 of MUL → out_valid_o never rises, in_ready_o=1 next cycle; async rst mid-DIV → all outputs at reset values.
